shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Multi-cycle controller that executes MIPS SLL/SRL/SRA (and optionally ROTR) on the team's serial universal shifter.
- Sits between the ALU decode stage and one external universal shifter instance (parameter n = N).
- Parallel-loads the operand, issues one serial shift per cycle for shamt cycles with the correct fill bit, then presents the result with a one-cycle done pulse.

Parameters:
N, 32, datapath width; must equal the shifter's n.
SHW, 5, shamt width; equals clog2(N).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
start  input  1  request strobe; sampled only in IDLE.
op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR or pass-through (see Optional Feature).
operand  input  N  value to shift; sampled with start.
shamt  input  SHW  shift amount, 0..N-1; sampled with start.
busy  output  1  high whenever state != IDLE.
done  output  1  high for exactly one cycle (state DONE).
result  output  N  shifted value.
sh_ctrl  output  2  to shifter ctrl: 00 hold, 01 load, 10 shift left, 11 shift right.
sh_data_in  output  N  to shifter data_in; equals the captured operand register.
sh_serial_in  output  1  to shifter serial_in.
sh_data_out  input  N  from shifter data_out.

Behaviour:
- Reset (asynchronous): state IDLE, operand_q/op_q/cnt/result_q = 0. Outputs: busy 0, done 0, sh_ctrl 00, sh_data_in 0, sh_serial_in 0, result 0. Reset during LOAD or SHIFT aborts immediately. No done is issued for the aborted request. The shifter is reset by the same rst.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: sh_ctrl 00. If start=1, capture operand, op, shamt and sign = operand[N-1], then go to LOAD.
- LOAD: sh_ctrl 01, cnt <= shamt. Next state is DONE if shamt==0, else SHIFT.
- SHIFT: sh_ctrl 10 for SLL, 11 for SRL/SRA/ROTR. cnt decrements each cycle. Go to DONE when cnt==1 (last shift edge).
- DONE: sh_ctrl 00, done=1, result driven combinationally from sh_data_out, result_q <= sh_data_out. Always return to IDLE.
- Outside DONE, result = result_q; the value is held until the next DONE.
- sh_serial_in fill bit: SLL 0, SRL 0, SRA captured sign, ROTR sh_data_out[0].
- Latency: start high in cycle 0 gives LOAD in cycle 1, SHIFT in cycles 2..shamt+1, DONE in cycle shamt+2. For shamt=0, DONE is in cycle 2.
- start while busy=1, including the DONE cycle, is ignored and not queued. Back-to-back throughput is one op per shamt+3 cycles.
- Inputs operand/op/shamt may change after acceptance without effect.
- shamt is unsigned. Values >= N are impossible when N is a power of two.

Optional Feature:
- Macro: SHIFT_SEQ_ROTATE_EN.
- Defined: op=11 is ROTR, a right shift with sh_serial_in = sh_data_out[0], i.e. rotate right by shamt.
- Undefined: op=11 is pass-through. The FSM runs LOAD then DONE regardless of shamt, result = operand, and done comes in cycle 2.

Decomposition:
- Package shift_seq_pkg:
  - sh_ctrl encodings: CTRL_HOLD, CTRL_LOAD, CTRL_SHL, CTRL_SHR.
  - op encodings: OP_SLL, OP_SRL, OP_SRA, OP_ROTR.
  - FSM state encodings.
- One natural sub-module: shift_counter, an SHW-bit loadable down-counter with a load/dec interface and a last flag (cnt==1).
- The shifter itself stays external and is instantiated at the parent level.

Test Plan:
- SLL, operand 0x0000_0001, shamt 4, start in cycle 0 -> done only in cycle 6, result 0x0000_0010, busy high in cycles 1..6.
- SRA, 0x8000_0000, shamt 31 -> done in cycle 33, result 0xFFFF_FFFF. SRL with the same inputs -> 0x0000_0001.
- SRL, 0x1234_5678, shamt 0 -> sh_ctrl 01 then done in cycle 2, result 0x1234_5678.
- start pulsed in cycles 3 and 6 of an SLL by 4 -> both ignored, single done. The result is held at 0x10 after done until the next request.
- rst asserted mid-SHIFT -> busy, done and sh_ctrl are 0 immediately, no done follows, result 0. A new SLL 0x3 by 1 afterwards -> 0x6.
- With SHIFT_SEQ_ROTATE_EN: ROTR 0x0000_0003 by 1 -> 0x8000_0001. Without it: op=11, shamt 7 -> result equals operand, done in cycle 2.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
//   Shared encodings for the shift sequencer: the shifter control codes, the
//   MIPS shift operation codes and the sequencer FSM states.
//
//   Configuration macro: SHIFT_SEQ_ROTATE_EN
//     defined   -> op 11 is ROTR (rotate right by shamt)
//     undefined -> op 11 is a pass-through (result = operand, no shifting)
// -----------------------------------------------------------------------------
package shift_seq_pkg;

  localparam int SEQ_N_DEFAULT   = 32;
  localparam int SEQ_SHW_DEFAULT = 5;

  // Control codes understood by the external universal shifter.
  typedef enum logic [1:0] {
    CTRL_HOLD = 2'b00,
    CTRL_LOAD = 2'b01,
    CTRL_SHL  = 2'b10,
    CTRL_SHR  = 2'b11
  } sh_ctrl_e;

  // Shift operations presented by the ALU decode stage.
  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // True when the operation never enters SHIFT: without rotate support op 11
  // degenerates to a pass-through of the loaded operand.
  function automatic logic op_skips_shift(input op_e op);
`ifdef SHIFT_SEQ_ROTATE_EN
    op_skips_shift = 1'b0;
`else
    op_skips_shift = (op == OP_ROTR);
`endif
  endfunction

endpackage : shift_seq_pkg

// File: rtl/shift_counter.sv
// -----------------------------------------------------------------------------
// shift_counter
//   SHW-bit loadable down-counter that tracks the remaining serial shifts.
//
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-high reset (count -> 0)
//     load      in   load load_val (has priority over dec)
//     dec       in   decrement by one
//     load_val  in   SHW  value to load
//     cnt       out  SHW  current count
//     last      out  high when cnt == 1, i.e. the current edge is the last shift
// -----------------------------------------------------------------------------
module shift_counter #(
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           dec,
  input  logic [SHW-1:0] load_val,
  output logic [SHW-1:0] cnt,
  output logic           last
);

  localparam logic [SHW-1:0] ONE = {{(SHW-1){1'b0}}, 1'b1};

  // NOTE: clocked state is always assigned with <= so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - ONE;
    end
  end

  assign last = (cnt == ONE);

endmodule : shift_counter

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//   Multi-cycle controller that executes MIPS SLL/SRL/SRA (and optionally
//   ROTR) on an external serial universal shifter. It parallel-loads the
//   operand, issues one serial shift per cycle for shamt cycles with the
//   proper fill bit, then presents the result with a one-cycle done pulse.
//
//   Timing: start in cycle 0 -> LOAD cycle 1 -> SHIFT cycles 2..shamt+1 ->
//   DONE cycle shamt+2 (shamt = 0 or pass-through: DONE in cycle 2).
//
//   Configuration macro: SHIFT_SEQ_ROTATE_EN (op 11 = ROTR when defined,
//   pass-through when undefined).
//
//   Ports:
//     clk           in   clock, rising edge
//     rst           in   asynchronous active-high reset (also resets shifter)
//     start         in   request strobe, sampled only in IDLE
//     op            in   2    00 SLL, 01 SRL, 10 SRA, 11 ROTR / pass-through
//     operand       in   N    value to shift, sampled with start
//     shamt         in   SHW  shift amount, sampled with start
//     busy          out  high whenever not IDLE
//     done          out  one-cycle pulse in DONE
//     result        out  N    shifted value (live in DONE, held otherwise)
//     sh_ctrl       out  2    shifter ctrl: 00 hold, 01 load, 10 shl, 11 shr
//     sh_data_in    out  N    shifter parallel input = captured operand
//     sh_serial_in  out  serial fill bit for the shifter
//     sh_data_out   in   N    shifter parallel output
// -----------------------------------------------------------------------------
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   operand,
  input  logic [SHW-1:0] shamt,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   result,
  output logic [1:0]     sh_ctrl,
  output logic [N-1:0]   sh_data_in,
  output logic           sh_serial_in,
  input  logic [N-1:0]   sh_data_out
);

  state_e         state_q, state_d;
  logic [N-1:0]   operand_q;
  op_e            op_q;
  logic [SHW-1:0] shamt_q;
  logic           sign_q;
  logic [N-1:0]   result_q;

  sh_ctrl_e       ctrl;
  logic           cnt_load;
  logic           cnt_dec;
  logic [SHW-1:0] cnt;
  logic           cnt_last;

  shift_counter #(.SHW(SHW)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (shamt_q),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  // Request capture and result hold. The request registers only change on an
  // accepted start, so later input activity cannot disturb a running op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      operand_q <= '0;
      op_q      <= OP_SLL;
      shamt_q   <= '0;
      sign_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        operand_q <= operand;
        op_q      <= op_e'(op);
        shamt_q   <= shamt;
        sign_q    <= operand[N-1];
      end
      if (state_q == ST_DONE) begin
        result_q <= sh_data_out;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ctrl     = CTRL_HOLD;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ctrl     = CTRL_LOAD;
        cnt_load = 1'b1;
        state_d  = (shamt_q == '0 || op_skips_shift(op_q)) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        ctrl    = (op_q == OP_SLL) ? CTRL_SHL : CTRL_SHR;
        cnt_dec = 1'b1;
        // cnt == 1 means this edge performs the final shift.
        if (cnt_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fill bit entering at the vacated end of the shifter.
  always_comb begin
    sh_serial_in = 1'b0;
    unique case (op_q)
      OP_SLL:  sh_serial_in = 1'b0;
      OP_SRL:  sh_serial_in = 1'b0;
      OP_SRA:  sh_serial_in = sign_q;
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROTR: sh_serial_in = sh_data_out[0];
`else
      OP_ROTR: sh_serial_in = 1'b0;
`endif
      default: sh_serial_in = 1'b0;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign sh_ctrl    = ctrl;
  assign sh_data_in = operand_q;
  // In DONE the shifter already holds the final value, so it is forwarded
  // directly rather than waiting a cycle for result_q.
  assign result     = (state_q == ST_DONE) ? sh_data_out : result_q;

endmodule : shift_sequencer
